poly_stream_reader: RTL and testbench
=====================================

POLY_STREAM_READER -- requirements
Module: poly_stream_reader

Interface
REQ-001 SHALL have parameter R_BITS, default 40973, polynomial length in bits.
REQ-002 SHALL have parameter B_WIDTH, default 32, BRAM word and stream width in bits.
REQ-003 SHALL have parameter WORDS, default SWORDS (1281), number of words per polynomial.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins unloading.
REQ-007 SHALL have port busy  output  1  high from the start pulse until the last beat is accepted.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last beat is accepted.
REQ-009 SHALL have port ram_ren  output  1  BRAM read enable.
REQ-010 SHALL have port ram_addr  output  LOGSWORDS  BRAM word address.
REQ-011 SHALL have port ram_dout  input  B_WIDTH  BRAM read data, valid one cycle after ram_ren.
REQ-012 SHALL have port m_valid  output  1  stream beat valid.
REQ-013 SHALL have port m_ready  input  1  stream consumer ready.
REQ-014 SHALL have port m_data  output  B_WIDTH  stream beat data.
REQ-015 SHALL have port m_last  output  1  high on the beat for word WORDS-1.

Function
REQ-016 SHALL implement the FSM states IDLE, READ, DRAIN and DONE.
REQ-017 SHALL go from IDLE to READ on start; start is ignored in every state except IDLE.
REQ-018 SHALL in READ issue addresses 0..WORDS-1 in ascending order, one per cycle, only while the in-flight plus buffered word count is below 2.
REQ-019 SHALL go from READ to DRAIN after issuing address WORDS-1.
REQ-020 SHALL go from DRAIN to DONE when the WORDS-1 beat handshakes (m_valid and m_ready both high).
REQ-021 SHALL go from DONE to IDLE after one cycle; done is high only while in DONE.
REQ-022 SHALL hold returned words in a 2-entry FIFO (skid buffer) so that no word is dropped or duplicated under any m_ready pattern.
REQ-023 SHALL keep m_data and m_last stable while m_valid is high and m_ready is low.
REQ-024 SHALL sustain one beat per cycle when m_ready is held high; first beat appears 2 cycles after start.
REQ-025 SHALL handle a simultaneous FIFO push and pop with the FIFO occupancy unchanged.
REQ-026 SHALL keep ram_ren low outside READ and ram_addr at 0 in IDLE.

Reset
REQ-027 SHALL on resetn low, at any time including mid-transfer, force state IDLE, FIFO empty and counters 0.
REQ-028 SHALL on resetn low force busy, done, ram_ren, m_valid and m_last low, and ram_addr and m_data to 0.

Configuration
REQ-029 SHALL, when OVERHANG_MASK_EN is defined, zero bits OVERHANG..B_WIDTH-1 of the last word (OVERHANG = R_BITS - B_WIDTH*(WORDS-1)).
REQ-030 SHALL, when OVERHANG_MASK_EN is not defined, pass the last word unmodified.

Structure
REQ-031 SHALL take SWORDS, OVERHANG, LOGSWORDS and B_WIDTH from BIKE_PACKAGE, and SHALL define the FSM state enum typedef there.
REQ-032 SHALL instantiate the 2-entry FIFO as sub-module poly_skid_fifo.

Verification
REQ-033 SHALL cover: BRAM word k = k, m_ready held 1 -> 1281 beats with data 0..1280, m_last only on beat 1280, done 1 cycle later.
REQ-034 SHALL cover: m_ready toggling 1,0,0,1 in a repeating pattern -> same 1281-beat sequence, no gaps or repeats, data stable while stalled.
REQ-035 SHALL cover: OVERHANG_MASK_EN defined, last word 0xFFFFFFFF -> m_data 0x00001FFF (OVERHANG=13); undefined -> 0xFFFFFFFF.
REQ-036 SHALL cover: start pulsed again while busy -> ignored, exactly one done pulse.
REQ-037 SHALL cover: resetn low at beat 500 -> all outputs 0 asynchronously, then a new start -> a full run from address 0.
REQ-038 SHALL cover: m_ready held 0 for 100 cycles after start -> at most 2 reads issued, no beat lost on release.

Source files
------------

// File: rtl/poly_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// BIKE_PACKAGE
// Shared constants and types for the polynomial stream reader.
//   R_BITS    : polynomial length in bits
//   B_WIDTH   : BRAM word / stream width in bits
//   SWORDS    : words needed to hold one polynomial
//   OVERHANG  : number of meaningful bits in the last word
//   LOGSWORDS : address width needed to index SWORDS words
//   reader_state_t : reader FSM state encoding
// -----------------------------------------------------------------------------
package BIKE_PACKAGE;

    localparam int R_BITS    = 40973;
    localparam int B_WIDTH   = 32;
    localparam int SWORDS    = (R_BITS + B_WIDTH - 1) / B_WIDTH;
    localparam int OVERHANG  = R_BITS - B_WIDTH * (SWORDS - 1);
    localparam int LOGSWORDS = $clog2(SWORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/poly_skid_fifo.sv
// -----------------------------------------------------------------------------
// poly_skid_fifo
// Two-entry FIFO used as a skid buffer between the BRAM return path and the
// output stream. Head entry is held in a register so the stream data stays
// stable while the consumer stalls.
// Ports:
//   clk, resetn     : clock, asynchronous active-low reset
//   push, push_data : write one entry (ignored when full)
//   pop             : remove head entry (ignored when empty)
//   count           : current occupancy 0..2
//   head            : oldest entry (meaningful when count != 0)
// -----------------------------------------------------------------------------
module poly_skid_fifo
    import BIKE_PACKAGE::*;
#(
    parameter int W = B_WIDTH + 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok_s;
    logic         pop_ok_s;

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        mem0_d    = mem0_q;
        mem1_d    = mem1_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        push_ok_s = push && (count_q != 2'd2);
        pop_ok_s  = pop && (count_q != 2'd0);

        if (push_ok_s) begin
            if (wr_ptr_q) begin
                mem1_d = push_data;
            end else begin
                mem0_d = push_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        count = count_q;
        if (rd_ptr_q) begin
            head = mem1_q;
        end else begin
            head = mem0_q;
        end
    end

endmodule

// File: rtl/poly_stream_reader.sv
// -----------------------------------------------------------------------------
// poly_stream_reader
// Unloads one polynomial (WORDS words) from a BRAM with one-cycle read latency
// and presents it as a valid/ready stream. Reads are credit-limited so that
// words requested-but-not-yet-buffered plus buffered words never exceed the
// two-entry skid FIFO; with m_ready held high one beat per cycle is sustained.
// The start pulse is sampled at a rising edge; the first beat is valid after
// the second following rising edge.
//
// Optional build macro: OVERHANG_MASK_EN -- when defined, bits above the
// polynomial length in the last word are forced to zero.
//
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   start       : one-cycle pulse, honoured only in IDLE
//   busy        : high from start until the last beat is accepted
//   done        : one-cycle pulse after the last beat is accepted
//   ram_ren     : BRAM read enable
//   ram_addr    : BRAM word address
//   ram_dout    : BRAM read data, valid one cycle after ram_ren
//   m_valid, m_ready, m_data, m_last : output stream
// -----------------------------------------------------------------------------
module poly_stream_reader
    import BIKE_PACKAGE::reader_state_t;
    import BIKE_PACKAGE::IDLE;
    import BIKE_PACKAGE::READ;
    import BIKE_PACKAGE::DRAIN;
    import BIKE_PACKAGE::DONE;
    import BIKE_PACKAGE::LOGSWORDS;
    import BIKE_PACKAGE::SWORDS;
#(
    parameter int R_BITS  = BIKE_PACKAGE::R_BITS,
    parameter int B_WIDTH = BIKE_PACKAGE::B_WIDTH,
    parameter int WORDS   = SWORDS
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_ren,
    output logic [LOGSWORDS-1:0] ram_addr,
    input  logic [B_WIDTH-1:0]   ram_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [B_WIDTH-1:0]   m_data,
    output logic                 m_last
);

    // Meaningful bits of the last word; equals BIKE_PACKAGE::OVERHANG at the
    // default parameter values.
    localparam int OVH_BITS = R_BITS - B_WIDTH * (WORDS - 1);
    localparam logic [B_WIDTH-1:0] OVH_MASK =
        {B_WIDTH{1'b1}} >> (B_WIDTH - OVH_BITS);
    localparam logic [LOGSWORDS-1:0] LAST_ADDR = LOGSWORDS'(WORDS - 1);

`ifdef OVERHANG_MASK_EN
    localparam logic MASK_EN = 1'b1;
`else
    localparam logic MASK_EN = 1'b0;
`endif

    reader_state_t        state_q, state_d;
    logic [LOGSWORDS-1:0] addr_cnt_q, addr_cnt_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rlast_q, rlast_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [1:0]           fifo_count_s;
    logic [B_WIDTH:0]     fifo_head_s;
    logic [B_WIDTH:0]     push_entry_s;
    logic [B_WIDTH-1:0]   push_word_s;
    logic                 head_valid_s;
    logic                 head_last_s;
    logic                 pop_s;
    logic [2:0]           level_s;
    logic                 ren_s;
    logic                 last_addr_s;

    // Read credit and handshake decode.
    always_comb begin
        head_valid_s = (fifo_count_s != 2'd0);
        head_last_s  = fifo_head_s[B_WIDTH];
        pop_s        = head_valid_s && m_ready;
        // Words that will occupy the FIFO next cycle if no new read is issued:
        // buffered words plus the word returning now, minus the one leaving.
        level_s      = {1'b0, fifo_count_s} + {2'b00, rvalid_q} - {2'b00, pop_s};
        ren_s        = (state_q == READ) && (level_s < 3'd2);
        last_addr_s  = (addr_cnt_q == LAST_ADDR);
    end

    // Returning word is tagged with its last flag and optionally masked.
    always_comb begin
        if (MASK_EN && rlast_q) begin
            push_word_s = ram_dout & OVH_MASK;
        end else begin
            push_word_s = ram_dout;
        end
        push_entry_s = {rlast_q, push_word_s};
    end

    poly_skid_fifo #(
        .W (B_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rvalid_q),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // FSM next-state and datapath-counter logic.
    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        case (state_q)
            IDLE: begin
                addr_cnt_d = '0;
                if (start) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (ren_s && last_addr_s) begin
                    state_d    = DRAIN;
                    addr_cnt_d = '0;
                end else if (ren_s) begin
                    state_d    = READ;
                    addr_cnt_d = addr_cnt_q + LOGSWORDS'(1);
                end else begin
                    state_d    = READ;
                    addr_cnt_d = addr_cnt_q;
                end
            end
            DRAIN: begin
                addr_cnt_d = '0;
                if (pop_s && head_last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                addr_cnt_d = '0;
                state_d    = IDLE;
            end
            default: begin
                addr_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase

        rvalid_d = ren_s;
        rlast_d  = ren_s && last_addr_s;
        busy_d   = (state_d == READ) || (state_d == DRAIN);
        done_d   = (state_d == DONE);
    end

    // State and control registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Output decode. ram_ren depends on m_ready so a read can be issued in
    // the same cycle a beat leaves, which is what sustains full throughput.
    always_comb begin
        busy    = busy_q;
        done    = done_q;
        ram_ren = ren_s;
        if (state_q == READ) begin
            ram_addr = addr_cnt_q;
        end else begin
            ram_addr = '0;
        end
        m_valid = head_valid_s;
        m_data  = fifo_head_s[B_WIDTH-1:0];
        m_last  = head_valid_s && head_last_s;
    end

endmodule

// File: tb/tb_poly_stream_reader.sv
module tb_poly_stream_reader;

    localparam int WORDS = 1281;
    localparam int MODE_ALWAYS = 0;
    localparam int MODE_TOGGLE = 1;
    localparam int MODE_STALL  = 2;

`ifdef OVERHANG_MASK_EN
    localparam logic [31:0] EXP_FF = 32'h0000_1FFF;
`else
    localparam logic [31:0] EXP_FF = 32'hFFFF_FFFF;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        ram_ren;
    logic [10:0] ram_addr;
    logic [31:0] ram_dout = 32'd0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;

    logic [31:0] bram [0:WORDS-1];
    int reads_cnt = 0;
    int done_cnt  = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    typedef struct {
        int          mode;
        int          restart_at;
        logic [31:0] last_word;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [5];

    poly_stream_reader dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ram_ren  (ram_ren),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    // BRAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_ren) ram_dout <= bram[ram_addr];
    end

    // Count read requests and done cycles.
    always @(posedge clk) begin
        if (ram_ren) reads_cnt <= reads_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({busy, done, ram_ren, m_valid, m_last} == 5'b0 && ram_addr == 11'd0 && m_data == 32'd0,
            name, {busy, done, ram_ren, m_valid, m_last, ram_addr, m_data}, 0);
    endtask

    // One full unload; abort_beat >= 0 pulls resetn when that beat is offered.
    task automatic run_vec(input int mode, input int restart_at, input logic [31:0] exp_last,
                           input int abort_beat);
        int beat = 0;
        int first_valid = -1;
        bit finished = 1'b0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_data = 32'd0;
        logic prev_last = 1'b0;
        logic [31:0] exp;
        int reads0;
        int dones0;
        reads0 = reads_cnt;
        dones0 = done_cnt;
        @(negedge clk); start = 1'b1; m_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        chk(busy == 1'b1, "busy_after_start", busy, 1);
        for (int c = 0; c < 20000 && !finished; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            case (mode)
                MODE_TOGGLE: m_ready = ((c % 4) == 0) || ((c % 4) == 3);
                MODE_STALL:  m_ready = (c >= 100);
                default:     m_ready = 1'b1;
            endcase
            if (mode == MODE_STALL && c == 100)
                chk(reads_cnt - reads0 == 2, "reads_while_stalled", reads_cnt - reads0, 2);
            if (c == 10) chk(busy == 1'b1, "busy_mid_run", busy, 1);
            if (prev_stall)
                chk(m_valid && m_data == prev_data && m_last == prev_last, "stall_hold",
                    {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            if (m_valid && first_valid < 0) first_valid = c;
            if (m_valid && m_ready) begin
                if (abort_beat >= 0 && beat == abort_beat) begin
                    #2 resetn = 1'b0;
                    #1 chk_outputs_zero("async_reset_outputs");
                    chk(m_valid == 1'b0, "async_reset_valid", m_valid, 0);
                    start = 1'b0;
                    m_ready = 1'b0;
                    return;
                end
                exp = (beat == WORDS - 1) ? exp_last : 32'(beat);
                chk(m_data == exp && m_last == (beat == WORDS - 1), "beat",
                    {m_last, m_data}, {(beat == WORDS - 1), exp});
                beat++;
                if (beat == WORDS) finished = 1'b1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
        start = 1'b0;
        chk(finished, "beats_timeout", beat, WORDS);
        chk(first_valid == 1, "first_beat_latency", first_valid, 1);
        @(negedge clk);
        chk(done == 1'b1 && busy == 1'b0, "done_pulse", {done, busy}, 2'b10);
        @(negedge clk);
        chk(done == 1'b0 && busy == 1'b0, "done_cleared", {done, busy}, 2'b00);
        chk(ram_ren == 1'b0 && ram_addr == 11'd0, "idle_ram_quiet", {ram_ren, ram_addr}, 0);
        chk(done_cnt - dones0 == 1, "done_count", done_cnt - dones0, 1);
        chk(reads_cnt - reads0 == WORDS, "read_count", reads_cnt - reads0, WORDS);
    endtask

    initial begin
        vecs[0] = '{MODE_ALWAYS, -1, 32'd1280, 32'd1280};
        vecs[1] = '{MODE_TOGGLE, -1, 32'd1280, 32'd1280};
        vecs[2] = '{MODE_ALWAYS, -1, 32'hFFFF_FFFF, EXP_FF};
        vecs[3] = '{MODE_ALWAYS, 50, 32'd1280, 32'd1280};
        vecs[4] = '{MODE_STALL, -1, 32'd1280, 32'd1280};

        for (int k = 0; k < WORDS; k++) bram[k] = 32'(k);

        #3;
        chk_outputs_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk_outputs_zero("idle_after_reset");

        for (int i = 0; i < 5; i++) begin
            bram[WORDS-1] = vecs[i].last_word;
            run_vec(vecs[i].mode, vecs[i].restart_at, vecs[i].exp_last, -1);
        end

        bram[WORDS-1] = 32'd1280;
        run_vec(MODE_ALWAYS, -1, 32'd1280, 500);
        @(negedge clk);
        chk_outputs_zero("held_in_reset");
        resetn = 1'b1;
        @(negedge clk);
        chk_outputs_zero("idle_after_abort");
        run_vec(MODE_ALWAYS, -1, 32'd1280, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
